// File: rtl/inst_loader_pkg.sv
// rtl/inst_loader_pkg.sv - shared loader state encoding and stream/memory constants
package inst_loader_pkg;

  typedef enum logic [2:0] {
    ST_HDR_HI,
    ST_HDR_LO,
    ST_DATA,
    ST_FLUSH,
    ST_DONE
  } state_e;

  localparam int HDR_BYTES   = 2;
  localparam int IMEM_ADDR_W = 6;

endpackage

// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - length-prefixed byte stream to instruction-memory loader
// Holds the CPU in reset until all N big-endian words are written from address 0.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

  state_e              state_q, state_d;
  logic [15:0]         n_q, n_d;
  logic [15:0]         widx_q, widx_d;
  logic [1:0]          bcnt_q, bcnt_d;
  // Only the three earlier bytes are stored; the fourth completes the word directly.
  logic [23:0]         asm_q, asm_d;
  logic                err_q, err_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;

  logic                accept;
  logic [31:0]         word;
  logic                in_range;

  assign in_ready = (state_q == ST_HDR_HI) || (state_q == ST_HDR_LO) || (state_q == ST_DATA);
  assign accept   = in_valid && in_ready;
  assign word     = {asm_q, in_data};
  assign in_range = {1'b0, widx_q} < DEPTH;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_HDR_HI;
      n_q     <= '0;
      widx_q  <= '0;
      bcnt_q  <= '0;
      asm_q   <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      widx_q  <= widx_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    widx_d  = widx_q;
    bcnt_d  = bcnt_q;
    asm_d   = asm_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    case (state_q)
      ST_HDR_HI: begin
        if (accept) begin
          n_d     = {in_data, n_q[7:0]};
          state_d = ST_HDR_LO;
        end
      end
      ST_HDR_LO: begin
        if (accept) begin
          n_d     = {n_q[15:8], in_data};
          state_d = ({n_q[15:8], in_data} == 16'd0) ? ST_FLUSH : ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept) begin
          asm_d  = word[23:0];
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            // Out-of-range words are still consumed so the stream stays aligned.
            if (in_range) begin
              we_d    = 1'b1;
              addr_d  = widx_q[ADDR_W-1:0];
              wdata_d = word;
            end else begin
              err_d = 1'b1;
            end
            widx_d = widx_q + 16'd1;
            if (widx_q + 16'd1 == n_q) begin
              state_d = ST_FLUSH;
            end
          end
        end
      end
      ST_FLUSH: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (reload) begin
          state_d = ST_HDR_HI;
          err_d   = 1'b0;
          widx_d  = '0;
          bcnt_d  = '0;
          asm_d   = '0;
          n_d     = '0;
        end
      end
      default: state_d = ST_HDR_HI;
    endcase
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = (state_q != ST_DONE);
  assign done       = (state_q == ST_DONE);
  assign err        = err_q;

endmodule

// File: tb/tb_inst_loader.sv
// tb/tb_inst_loader.sv - scoreboard bench for inst_loader (default depth and a 4-word instance)
module tb_inst_loader;
  import inst_loader_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  a_data = '0, b_data = '0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic        a_reload = 1'b0, b_reload = 1'b0;
  logic        a_ready, b_ready;
  logic        a_we, b_we;
  logic [5:0]  a_addr;
  logic [1:0]  b_addr;
  logic [31:0] a_wdata, b_wdata;
  logic        a_hold, b_hold, a_done, b_done, a_err, b_err;

  inst_loader #(.ADDR_W(6)) dut_a (
    .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .reload(a_reload), .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
    .cpu_hold(a_hold), .done(a_done), .err(a_err)
  );

  inst_loader #(.ADDR_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .reload(b_reload), .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
    .cpu_hold(b_hold), .done(b_done), .err(b_err)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int byte_cnt [2];
  logic [63:0] qa [$];
  logic [63:0] qb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Write monitors: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (a_we === 1'b1) begin
      n_checks++;
      if (qa.size() == 0) begin
        n_fails++;
        $display("FAIL a_unexpected_write: got addr %0d data 0x%0h expected no write", a_addr, a_wdata);
      end else begin
        logic [63:0] e;
        e = qa.pop_front();
        if ({32'(a_addr), a_wdata} !== e) begin
          n_fails++;
          $display("FAIL a_write: got addr %0d data 0x%0h expected addr %0d data 0x%0h",
                   a_addr, a_wdata, e[63:32], e[31:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (b_we === 1'b1) begin
      n_checks++;
      if (qb.size() == 0) begin
        n_fails++;
        $display("FAIL b_unexpected_write: got addr %0d data 0x%0h expected no write", b_addr, b_wdata);
      end else begin
        logic [63:0] e;
        e = qb.pop_front();
        if ({32'(b_addr), b_wdata} !== e) begin
          n_fails++;
          $display("FAIL b_write: got addr %0d data 0x%0h expected addr %0d data 0x%0h",
                   b_addr, b_wdata, e[63:32], e[31:0]);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send(input int sel, input logic [7:0] b, input int gap);
    logic rdy;
    logic ok;
    ok = 1'b0;
    repeat (gap) @(negedge clk);
    if (sel == 0) begin a_valid = 1'b1; a_data = b; end
    else          begin b_valid = 1'b1; b_data = b; end
    for (int t = 0; t < 50; t++) begin
      rdy = (sel == 0) ? a_ready : b_ready;
      @(posedge clk);
      @(negedge clk);
      if (rdy) begin ok = 1'b1; break; end
    end
    if (sel == 0) a_valid = 1'b0; else b_valid = 1'b0;
    if (ok) byte_cnt[sel]++;
    else begin
      n_checks++;
      n_fails++;
      $display("FAIL send_timeout: got no acceptance expected byte 0x%0h accepted", b);
    end
  endtask

  task automatic send_word(input int sel, input logic [31:0] w, input int maxgap);
    for (int i = 3; i >= 0; i--) begin
      logic [31:0] tmp;
      tmp = w >> (8 * i);
      send(sel, tmp[7:0], (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
    end
  endtask

  task automatic wait_done(input int sel);
    for (int t = 0; t < 200; t++) begin
      if (((sel == 0) ? a_done : b_done) === 1'b1) return;
      @(negedge clk);
    end
    chk("wait_done_timeout", 32'(sel == 0 ? a_done : b_done), 32'd1);
  endtask

  // Reload pulse with the next header byte already offered in the same cycle.
  task automatic do_reload(input int sel, input logic [7:0] first);
    if (sel == 0) begin a_reload = 1'b1; a_valid = 1'b1; a_data = first; end
    else          begin b_reload = 1'b1; b_valid = 1'b1; b_data = first; end
    @(posedge clk);
    #1;
    chk("reload_hold", 32'(sel == 0 ? a_hold : b_hold), 32'd1);
    chk("reload_done", 32'(sel == 0 ? a_done : b_done), 32'd0);
    chk("reload_err", 32'(sel == 0 ? a_err : b_err), 32'd0);
    @(negedge clk);
    a_reload = 1'b0;
    b_reload = 1'b0;
  endtask

  initial begin
    byte_cnt[0] = 0;
    byte_cnt[1] = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state.
    chk("rst_hold", 32'(a_hold), 32'd1);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_we", 32'(a_we), 32'd0);
    chk("rst_addr", 32'(a_addr), 32'd0);
    chk("rst_wdata", a_wdata, 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    chk("rst_ready", 32'(a_ready), 32'd1);

    // Basic load, one byte per cycle.
    qa.push_back({32'd0, 32'h2001_0005});
    qa.push_back({32'd1, 32'h8C02_0004});
    send(0, 8'h00, 0);
    send(0, 8'h02, 0);
    send_word(0, 32'h2001_0005, 0);
    send_word(0, 32'h8C02_0004, 0);
    chk("basic_last_we", 32'(a_we), 32'd1);
    chk("basic_done_early", 32'(a_done), 32'd0);
    chk("basic_ready_flush", 32'(a_ready), 32'd0);
    @(negedge clk);
    chk("basic_done", 32'(a_done), 32'd1);
    chk("basic_hold", 32'(a_hold), 32'd0);
    chk("basic_we_low", 32'(a_we), 32'd0);
    chk("basic_err", 32'(a_err), 32'd0);
    chk("basic_qempty", 32'(qa.size()), 32'd0);

    // Asynchronous reset from DONE, asserted mid-cycle.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_hold", 32'(a_hold), 32'd1);
    chk("async_rst_done", 32'(a_done), 32'd0);
    chk("async_rst_we", 32'(a_we), 32'd0);
    chk("async_rst_ready", 32'(a_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Gapped load of the same image.
    qa.push_back({32'd0, 32'h2001_0005});
    qa.push_back({32'd1, 32'h8C02_0004});
    send(0, 8'h00, $urandom_range(0, 5));
    send(0, 8'h02, $urandom_range(0, 5));
    send_word(0, 32'h2001_0005, 5);
    send_word(0, 32'h8C02_0004, 5);
    wait_done(0);
    chk("gap_qempty", 32'(qa.size()), 32'd0);

    // Empty image via reload.
    do_reload(0, 8'h00);
    send(0, 8'h00, 0);
    send(0, 8'h00, 0);
    chk("empty_done_early", 32'(a_done), 32'd0);
    chk("empty_we", 32'(a_we), 32'd0);
    @(negedge clk);
    chk("empty_done", 32'(a_done), 32'd1);

    // Reload with a one-word image overwriting address 0.
    do_reload(0, 8'h00);
    qa.push_back({32'd0, 32'hDEAD_BEEF});
    send(0, 8'h00, 0);
    send(0, 8'h01, 0);
    chk("reload_hold_mid", 32'(a_hold), 32'd1);
    send_word(0, 32'hDEAD_BEEF, 2);
    wait_done(0);
    chk("reload_qempty", 32'(qa.size()), 32'd0);

    // Mid-load reset after two data bytes: partial word must be dropped.
    do_reload(0, 8'h00);
    send(0, 8'h00, 0);
    send(0, 8'h01, 0);
    send(0, 8'h11, 0);
    send(0, 8'h22, 0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_we", 32'(a_we), 32'd0);
    chk("midrst_ready", 32'(a_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    qa.push_back({32'd0, 32'hCAFE_BABE});
    send(0, 8'h00, 0);
    send(0, 8'h01, 0);
    send_word(0, 32'hCAFE_BABE, 0);
    wait_done(0);
    chk("midrst_qempty", 32'(qa.size()), 32'd0);

    // Overflow on the 4-word instance: 6 words, only addresses 0..3 written.
    byte_cnt[1] = 0;
    for (int i = 0; i < 4; i++) qb.push_back({32'(i), {8'(i), 8'(i + 16), 8'(i + 32), 8'(i + 48)}});
    send(1, 8'h00, 0);
    send(1, 8'h06, 1);
    for (int i = 0; i < 6; i++) begin
      send_word(1, {8'(i), 8'(i + 16), 8'(i + 32), 8'(i + 48)}, 1);
      if (i == 3) chk("ovf_err_before", 32'(b_err), 32'd0);
      if (i == 4) chk("ovf_err_set", 32'(b_err), 32'd1);
    end
    wait_done(1);
    chk("ovf_done", 32'(b_done), 32'd1);
    chk("ovf_err", 32'(b_err), 32'd1);
    chk("ovf_bytes", 32'(byte_cnt[1]), 32'(HDR_BYTES + 4 * 6));
    chk("ovf_qempty", 32'(qb.size()), 32'd0);
    do_reload(1, 8'h00);
    chk("ovf_err_cleared", 32'(b_err), 32'd0);

    repeat (4) @(negedge clk);
    chk("final_qa_empty", 32'(qa.size()), 32'd0);
    chk("final_qb_empty", 32'(qb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
